// File: rtl/spi_slave_core_pkg.sv
// Shared types and helpers for the oversampled SPI slave.
//  frame_state_e : frame tracking FSM states (idle between frames, active while CS is low)
//  MIN_SYNC_STAGES : smallest synchroniser depth allowed; shallower requests are clamped up
//  cnt_width()   : bit-counter width for a given word size
package spi_slave_core_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } frame_state_e;

  localparam int unsigned MIN_SYNC_STAGES = 2;

  // Counter must index bits 0..w-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser with registered level and edge pulses.
//  clk, rst_n : system clock, async active-low reset
//  d          : asynchronous input pin
//  level      : synchronised level (one flop after the chain)
//  rise, fall : 1-cycle pulses, aligned with the cycle in which level changes
//  RST_VAL    : reset value of the whole chain, so release produces no edge
module spi_sync_edge
  import spi_slave_core_pkg::*;
#(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned DEPTH = (STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : STAGES;

  logic [DEPTH-1:0] chain;

  // Synchroniser chain plus edge detection against the previous level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {DEPTH{RST_VAL}};
      level <= RST_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[DEPTH-2:0], d};
      level <= chain[DEPTH-1];
      rise  <= chain[DEPTH-1] & ~level;
      fall  <= ~chain[DEPTH-1] & level;
    end
  end

endmodule

// File: rtl/spi_slave_core.sv
// Oversampled, parametrised SPI slave core.
//  Pins    : spi_clk, spi_cs_n, spi_mosi in; spi_miso, spi_miso_oe out
//  RX      : rx_data (held), rx_stb pulse, rx_first (first word of frame, with rx_stb)
//  TX      : tx_data/tx_valid/tx_ready one-entry holding buffer, tx_underrun pulse
//  Status  : frame_abort pulse, csn_state, csn_rise/csn_fall pulses
// Needs f(clk) >= 8 x f(SCK); all pins pass through SYNC_STAGES flops.
module spi_slave_core
  import spi_slave_core_pkg::*;
#(
  parameter int unsigned     WIDTH       = 8,
  parameter bit              CPOL        = 1'b0,
  parameter bit              CPHA        = 1'b0,
  parameter bit              MSB_FIRST   = 1'b1,
  parameter int unsigned     SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] TX_IDLE    = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             spi_mosi,
  output logic             spi_miso,
  output logic             spi_miso_oe,
  input  logic             spi_cs_n,
  input  logic             spi_clk,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_stb,
  output logic             rx_first,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx_underrun,
  output logic             frame_abort,
  output logic             csn_state,
  output logic             csn_rise,
  output logic             csn_fall
);

  localparam int unsigned DEPTH = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;
  localparam int unsigned CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  // SCK level right after the edge on which MOSI is sampled.
  localparam logic SAMPLE_LEVEL = (CPOL == CPHA) ? 1'b1 : 1'b0;

  frame_state_e state, state_next;

  logic             sck_level, sck_rise, sck_fall;
  logic [DEPTH:0]   mosi_chain;
  logic             mosi_bit;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] rx_shift, tx_shift, hold_data;
  logic             first_pending;

  logic             sck_edge_c, active_c, start_c, load_c, sample_c, shift_c;
  logic             word_done_c, abort_c, first_drive_c, underrun_c;
  logic [WIDTH-1:0] load_word_c, rx_next_c;

  function automatic logic out_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] drop_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  // CS_n synchroniser: idles deasserted so reset release is edge-free.
  spi_sync_edge #(.STAGES(DEPTH), .RST_VAL(1'b1)) u_cs_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (spi_cs_n),
    .level (csn_state),
    .rise  (csn_rise),
    .fall  (csn_fall)
  );

  // SCK synchroniser: idles at CPOL.
  spi_sync_edge #(.STAGES(DEPTH), .RST_VAL(CPOL)) u_sck_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (spi_clk),
    .level (sck_level),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  // MOSI delayed by the same depth as the SCK level so samples line up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mosi_chain <= '0;
    else        mosi_chain <= {mosi_chain[DEPTH-1:0], spi_mosi};
  end
  assign mosi_bit = mosi_chain[DEPTH];

  assign spi_miso_oe = ~csn_state;

  // Frame state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Frame tracking and per-cycle control strobes.
  always_comb begin
    state_next    = state;
    start_c       = 1'b0;
    active_c      = 1'b0;
    load_c        = 1'b0;
    sample_c      = 1'b0;
    shift_c       = 1'b0;
    word_done_c   = 1'b0;
    abort_c       = 1'b0;
    first_drive_c = 1'b0;
    sck_edge_c    = sck_rise | sck_fall;
    case (state)
      ST_IDLE: begin
        if (csn_fall) begin
          state_next    = ST_ACTIVE;
          start_c       = 1'b1;
          load_c        = 1'b1;
          first_drive_c = ~CPHA;
        end
      end
      ST_ACTIVE: begin
        if (csn_rise) begin
          state_next = ST_IDLE;
          abort_c    = (bit_cnt != '0);
        end else begin
          active_c    = ~csn_state;
          sample_c    = active_c & sck_edge_c & (sck_level == SAMPLE_LEVEL);
          shift_c     = active_c & sck_edge_c & (sck_level != SAMPLE_LEVEL);
          word_done_c = sample_c & (bit_cnt == LAST_BIT);
          load_c      = word_done_c;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Word source for a load and the shifted-in RX word.
  always_comb begin
    underrun_c  = load_c & tx_ready;
    load_word_c = tx_ready ? TX_IDLE : hold_data;
    rx_next_c   = MSB_FIRST ? {rx_shift[WIDTH-2:0], mosi_bit}
                            : {mosi_bit, rx_shift[WIDTH-1:1]};
  end

  // RX path, bit counter and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt       <= '0;
      rx_shift      <= '0;
      rx_data       <= '0;
      rx_stb        <= 1'b0;
      rx_first      <= 1'b0;
      first_pending <= 1'b0;
      tx_underrun   <= 1'b0;
      frame_abort   <= 1'b0;
    end else begin
      rx_stb      <= 1'b0;
      rx_first    <= 1'b0;
      tx_underrun <= underrun_c;
      frame_abort <= abort_c;
      if (start_c) begin
        bit_cnt       <= '0;
        first_pending <= 1'b1;
      end
      if (csn_rise) begin
        bit_cnt  <= '0;
        rx_shift <= '0;
      end
      if (sample_c) begin
        rx_shift <= rx_next_c;
        if (word_done_c) begin
          bit_cnt       <= '0;
          rx_data       <= rx_next_c;
          rx_stb        <= 1'b1;
          rx_first      <= first_pending;
          first_pending <= 1'b0;
        end else begin
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end
    end
  end

  // TX holding buffer and MISO shifter. A load and an accept never
  // collide: a load only empties a full buffer, an accept only fills an empty one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_ready  <= 1'b1;
      hold_data <= '0;
      tx_shift  <= '0;
      spi_miso  <= 1'b0;
    end else begin
      if (load_c && !tx_ready) tx_ready <= 1'b1;
      if (tx_valid && tx_ready) begin
        hold_data <= tx_data;
        tx_ready  <= 1'b0;
      end
      if (load_c) begin
        // CPHA=0 must present the first bit before the first SCK edge.
        if (first_drive_c) begin
          spi_miso <= out_bit(load_word_c);
          tx_shift <= drop_bit(load_word_c);
        end else begin
          tx_shift <= load_word_c;
        end
      end else if (shift_c) begin
        spi_miso <= out_bit(tx_shift);
        tx_shift <= drop_bit(tx_shift);
      end
    end
  end

endmodule
